// File: rtl/pushbutton_debouncer_pkg.sv
// Shared types and helpers for the pushbutton debouncer.
// The debouncer top module and the per-key channel both import this package.
package pushbutton_pkg;

    typedef enum logic {
        DB_STABLE,
        DB_CHANGING
    } db_state_t;

    localparam int SYNC_STAGES = 2;

    // Pin level that means "not pressed" for the given polarity.
    function automatic logic released_level(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/pushbutton_debouncer_channel.sv
// One debounce channel: two-flop synchroniser, stability counter, STABLE/CHANGING FSM
// and one-cycle press/release strobes for a single key.
module debounce_channel
    import pushbutton_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_key_raw,
    output logic o_key_db,
    output logic o_key_db_next,
    output logic o_press_pulse,
    output logic o_release_pulse
);

    localparam logic             RELEASED = released_level(ACTIVE_LOW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    db_state_t              r_state;
    db_state_t              w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   r_db;
    logic                   w_db_next;
    logic                   r_press;
    logic                   r_release;
    logic                   w_press_next;
    logic                   w_release_next;
    logic                   w_s2;

    assign w_s2 = r_sync[SYNC_STAGES-1];

    // Synchroniser resets to the released level so leaving reset never looks like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= {SYNC_STAGES{RELEASED}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_key_raw};
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_db_next      = r_db;
        w_press_next   = 1'b0;
        w_release_next = 1'b0;
        case (r_state)
            DB_STABLE: begin
                w_cnt_next = '0;
                if (w_s2 != r_db) begin
                    w_state_next = DB_CHANGING;
                    w_cnt_next   = CNT_ONE;
                end
            end
            DB_CHANGING: begin
                if (w_s2 == r_db) begin
                    w_state_next = DB_STABLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    // Level held long enough: accept it and strobe once.
                    w_state_next = DB_STABLE;
                    w_cnt_next   = '0;
                    w_db_next    = w_s2;
                    if (w_s2 == RELEASED) begin
                        w_release_next = 1'b1;
                    end else begin
                        w_press_next = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_next = DB_STABLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= DB_STABLE;
            r_cnt     <= '0;
            r_db      <= RELEASED;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_db      <= w_db_next;
            r_press   <= w_press_next;
            r_release <= w_release_next;
        end
    end

    assign o_key_db        = r_db;
    assign o_key_db_next   = w_db_next;
    assign o_press_pulse   = r_press;
    assign o_release_pulse = r_release;

endmodule

// File: rtl/pushbutton_debouncer.sv
// Conditions raw KEY pins into synchronised, debounced levels for the PIO,
// plus per-key press/release strobes and an any-pressed flag.
module pushbutton_debouncer
    import pushbutton_pkg::*;
#(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] key_raw,
    output logic [NUM_BUTTONS-1:0] key_db,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse,
    output logic                   any_pressed
);

    localparam int   CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic RELEASED = released_level(ACTIVE_LOW);

    logic [NUM_BUTTONS-1:0] w_db_next;
    logic                   r_any_pressed;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_channel
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW),
            .CNT_W           (CNT_W)
        ) u_channel (
            .clk             (clk),
            .reset_n         (reset_n),
            .i_key_raw       (key_raw[i]),
            .o_key_db        (key_db[i]),
            .o_key_db_next   (w_db_next[i]),
            .o_press_pulse   (press_pulse[i]),
            .o_release_pulse (release_pulse[i])
        );
    end

    // Built from the next debounced value so the flag changes on the same edge as key_db.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_any_pressed <= 1'b0;
        end else begin
            r_any_pressed <= (w_db_next != {NUM_BUTTONS{RELEASED}});
        end
    end

    assign any_pressed = r_any_pressed;

endmodule

// File: tb/tb_pushbutton_debouncer.sv
// Self-checking bench for pushbutton_debouncer (4 keys, 8-cycle debounce, active-low).
// Every cycle is compared against a sliding-window model; directed sequences add fixed expectations.
module tb_pushbutton_debouncer;

    localparam int NB = 4;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NB-1:0] key_raw = '0;
    logic [NB-1:0] key_db;
    logic [NB-1:0] press_pulse;
    logic [NB-1:0] release_pulse;
    logic          any_pressed;

    int checks = 0;
    int failures = 0;

    pushbutton_debouncer #(
        .NUM_BUTTONS     (NB),
        .DEBOUNCE_CYCLES (DB),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .key_raw       (key_raw),
        .key_db        (key_db),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .any_pressed   (any_pressed)
    );

    always #5 clk = ~clk;

    // Reference: a key's level is accepted once its last DB synchronised samples all differ from it.
    logic [NB-1:0] mS1, mS2, mDb, mPress, mRelease;
    logic          mAny;
    logic [DB-1:0] mWin [NB];

    task automatic modelReset();
        mS1 = '1; mS2 = '1; mDb = '1;
        mPress = '0; mRelease = '0; mAny = 1'b0;
        for (int c = 0; c < NB; c++) mWin[c] = '1;
    endtask

    task automatic modelEdge(input logic [NB-1:0] raw);
        logic [NB-1:0] seen;
        seen = mS2;
        mS2 = mS1;
        mS1 = raw;
        mPress = '0;
        mRelease = '0;
        for (int c = 0; c < NB; c++) begin
            mWin[c] = {mWin[c][DB-2:0], seen[c]};
            if (mWin[c] == {DB{~mDb[c]}}) begin
                mDb[c] = seen[c];
                if (seen[c] == 1'b0) mPress[c] = 1'b1;
                else                 mRelease[c] = 1'b1;
            end
        end
        mAny = (mDb != '1);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) modelEdge(key_raw);
        else         modelReset();
        #1;
        checkOutput("model", {key_db, press_pulse, release_pulse, any_pressed},
                    {mDb, mPress, mRelease, mAny});
    endtask

    logic [NB-1:0] seenPress, seenRelease;

    task automatic applyStimulus(input logic [NB-1:0] raw, input int cycles);
        key_raw = raw;
        for (int k = 0; k < cycles; k++) begin
            tick();
            seenPress   |= press_pulse;
            seenRelease |= release_pulse;
        end
    endtask

    // Clean step: nothing moves for DB+1 edges, then key_db and strobes change on edge DB+1 only.
    task automatic cleanStep(input logic [NB-1:0] raw, input logic [NB-1:0] oldDb,
                             input logic [NB-1:0] newDb, input logic [NB-1:0] expPress,
                             input logic [NB-1:0] expRel, input string name);
        key_raw = raw;
        for (int e = 0; e <= DB + 1; e++) begin
            tick();
            if (e < DB + 1)
                checkOutput({name, "_hold"}, {key_db, press_pulse, release_pulse}, {oldDb, 8'h00});
            else
                checkOutput({name, "_accept"}, {key_db, press_pulse, release_pulse, any_pressed},
                            {newDb, expPress, expRel, (newDb != 4'hF)});
        end
        tick();
        checkOutput({name, "_strobe_end"}, {press_pulse, release_pulse}, 8'h00);
    endtask

    typedef struct {
        logic [NB-1:0] raw;
        int            cycles;
        logic [NB-1:0] expDb;
        logic [NB-1:0] expPress;
        logic [NB-1:0] expRel;
        logic          expAny;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int pressCount, relCount, pressEdge, relEdge;

        vecs[0] = '{4'hF, 12, 4'hF, 4'h0, 4'hF, 1'b0};
        vecs[1] = '{4'hF,  5, 4'hF, 4'h0, 4'h0, 1'b0};
        vecs[2] = '{4'h0,  5, 4'hF, 4'h0, 4'h0, 1'b0};
        vecs[3] = '{4'hF, 12, 4'hF, 4'h0, 4'h0, 1'b0};
        vecs[4] = '{4'hA, 12, 4'hA, 4'h5, 4'h0, 1'b1};
        vecs[5] = '{4'h5, 12, 4'h5, 4'hA, 4'h5, 1'b1};
        vecs[6] = '{4'hF, 12, 4'hF, 4'h0, 4'hA, 1'b0};

        modelReset();
        key_raw = 4'h0;
        reset_n = 1'b0;
        repeat (3) tick();
        checkOutput("reset_state", {key_db, press_pulse, release_pulse, any_pressed}, 13'h1E00);
        reset_n = 1'b1;
        cleanStep(4'h0, 4'hF, 4'h0, 4'hF, 4'h0, "reset_release");

        for (int i = 0; i < 7; i++) begin
            seenPress = '0;
            seenRelease = '0;
            applyStimulus(vecs[i].raw, vecs[i].cycles);
            checkOutput($sformatf("vec%0d", i), {key_db, seenPress, seenRelease, any_pressed},
                        {vecs[i].expDb, vecs[i].expPress, vecs[i].expRel, vecs[i].expAny});
        end

        cleanStep(4'hE, 4'hF, 4'hE, 4'h1, 4'h0, "press_ch0");

        for (int s = 0; s < 10; s++) begin
            key_raw = (s % 2 == 0) ? 4'hC : 4'hE;
            repeat (3) begin
                tick();
                checkOutput("bounce_ch1", {key_db, press_pulse, release_pulse}, {4'hE, 8'h00});
            end
        end
        cleanStep(4'hC, 4'hE, 4'hC, 4'h2, 4'h0, "bounce_hold_ch1");

        key_raw = 4'h8;
        repeat (7) tick();
        key_raw = 4'hC;
        for (int k = 0; k < 12; k++) begin
            tick();
            checkOutput("glitch7_ch2", {key_db, press_pulse, release_pulse}, {4'hC, 8'h00});
        end

        pressCount = 0; relCount = 0; pressEdge = -1; relEdge = -1;
        for (int e = 0; e <= 20; e++) begin
            key_raw = (e < 8) ? 4'h8 : 4'hC;
            tick();
            if (press_pulse[2])   begin pressCount++; pressEdge = e; end
            if (release_pulse[2]) begin relCount++;   relEdge = e;   end
        end
        checkOutput("glitch8_press_count", pressCount, 1);
        checkOutput("glitch8_press_edge", pressEdge, 9);
        checkOutput("glitch8_release_count", relCount, 1);
        checkOutput("glitch8_release_edge", relEdge, 17);

        cleanStep(4'h4, 4'hC, 4'h4, 4'h8, 4'h0, "press_ch3");
        cleanStep(4'hD, 4'h4, 4'hD, 4'h0, 4'h9, "release_ch0_ch3");
        cleanStep(4'h4, 4'hD, 4'h4, 4'h9, 4'h0, "repress_ch0_ch3");

        key_raw = 4'hD;
        for (int e = 0; e <= 6; e++) begin
            tick();
            checkOutput("count_before_reset", {key_db, press_pulse, release_pulse}, {4'h4, 8'h00});
        end
        reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("reset_mid_count", {key_db, press_pulse, release_pulse, any_pressed}, 13'h1E00);
        repeat (2) tick();
        checkOutput("reset_held", {key_db, press_pulse, release_pulse, any_pressed}, 13'h1E00);
        reset_n = 1'b1;
        cleanStep(4'hD, 4'hF, 4'hD, 4'h2, 4'h0, "reaccept_after_reset");

        for (int seg = 0; seg < 250; seg++) begin
            if (seg == 120) begin
                reset_n = 1'b0;
                #1;
                modelReset();
                checkOutput("random_reset", {key_db, press_pulse, release_pulse, any_pressed}, 13'h1E00);
                tick();
                reset_n = 1'b1;
            end
            key_raw = key_raw ^ 4'($urandom_range(0, 15));
            repeat ($urandom_range(1, 14)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pushbutton_debouncer.md
Name: pushbutton_debouncer

Overview:
- Upstream conditioning stage for the pushbutton PIO. Takes raw, asynchronous, bouncing KEY pins and produces synchronised, debounced levels that drive the PIO in_port directly.
- Keeps the board's active-low polarity, so the PIO's falling-edge capture still means "pressed".
- Also emits one-cycle press and release strobes for hardware consumers, such as the VGA image-select logic, that do not go through the CPU.

Parameters:
- NUM_BUTTONS, 4: number of independent channels.
- DEBOUNCE_CYCLES, 1000000: consecutive stable clk cycles required to accept a new level (20 ms at 50 MHz). Minimum legal value is 2.
- ACTIVE_LOW, 1: 1 means pressed = 0 on the pin; 0 means pressed = 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES): per-channel counter width. Derived; must not be overridden.

Ports:
- clk, input, 1: system clock, 50 MHz.
- reset_n, input, 1: asynchronous active-low reset.
- key_raw, input, NUM_BUTTONS: raw pin levels, asynchronous to clk.
- key_db, output, NUM_BUTTONS: debounced level, same polarity as key_raw; connects to PIO in_port.
- press_pulse, output, NUM_BUTTONS: one-cycle strobe when a channel becomes pressed.
- release_pulse, output, NUM_BUTTONS: one-cycle strobe when a channel becomes released.
- any_pressed, output, 1: OR of all channels currently in the debounced-pressed state.

Behaviour:
- Reset (async, reset_n=0):
  - Both synchroniser flops, key_db and the internal stable level are set to the released level: all 1s if ACTIVE_LOW, else all 0s.
  - Counters are set to 0; press_pulse, release_pulse and any_pressed are 0.
  - Result: releasing reset never produces a spurious edge at the PIO.
- Synchroniser:
  - Two-flop chain per bit, key_raw -> s1 -> s2.
  - s2 is the only signal the debounce logic samples.
- Per-channel FSM, states STABLE and CHANGING:
  - STABLE: counter = 0. If s2 != key_db, go to CHANGING with counter = 1.
  - CHANGING, s2 == key_db (bounce back): counter clears, go to STABLE. key_db unchanged, no pulse.
  - CHANGING, s2 != key_db and counter < DEBOUNCE_CYCLES-1: counter increments.
  - CHANGING, s2 != key_db and counter == DEBOUNCE_CYCLES-1: on that edge key_db takes s2, counter clears, go to STABLE, and the matching pulse is asserted for exactly this one following cycle.
- Latency:
  - A clean step on key_raw, set up before edge 0, appears on key_db after edge DEBOUNCE_CYCLES+1. That is DEBOUNCE_CYCLES+2 edges including sync.
  - The pulse is coincident with the key_db change.
- Glitch rejection:
  - Any level differing from key_db for fewer than DEBOUNCE_CYCLES consecutive s2 samples is ignored entirely.
  - A single sample matching key_db restarts the count.
- Pulses:
  - press_pulse[i] = 1 only in the cycle key_db[i] first shows the pressed level; release_pulse[i] likewise for the released level.
  - The two pulses are never high together on one channel.
- any_pressed is registered from key_db. It lags key_db by 0 cycles, meaning it is computed from the updated value on the same edge.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses.
- Counter saturation cannot occur: its width covers DEBOUNCE_CYCLES-1 and the counter clears on acceptance.
- Reset asserted mid-count: all state returns to reset values immediately and no pulse is emitted. After release, a held key is re-accepted after the full latency.

Decomposition:
- Shared package pushbutton_pkg holds:
  - typedef db_state_t {DB_STABLE, DB_CHANGING};
  - localparam SYNC_STAGES = 2;
  - function released_level(ACTIVE_LOW).
- One natural sub-module, debounce_channel. It contains the synchroniser, counter, FSM and pulse logic for a single bit.
- The top instantiates it NUM_BUTTONS times in a generate loop and ORs the outputs for any_pressed.

Test Plan:
All cases use DEBOUNCE_CYCLES=8 and ACTIVE_LOW=1.
- Reset: hold reset_n=0 with key_raw=4'b0000, then release -> key_db=4'hF, no pulses for 3 cycles. After 10 edges, key_db=4'h0 and press_pulse=4'hF for exactly one cycle.
- Clean press on ch0: key_raw 1->0 before edge 0 -> key_db[0]=0 after edge 9 (not before), press_pulse[0]=1 during cycle 9 only, any_pressed=1.
- Bounce on ch1: toggle key_raw[1] 0/1 every 3 cycles for 30 cycles, then hold 0 -> no pulse during the bounce. key_db[1] falls exactly 10 edges after the final hold begins, with a single press_pulse.
- Glitch on ch2: 7-cycle low pulse -> key_db[2] stays 1 and no pulses. 8-cycle low pulse -> one press_pulse, then one release_pulse 8 cycles later.
- Simultaneous and reset mid-count: release ch0 and ch3 on the same edge -> both release_pulse bits high in the same cycle. Repeat with reset_n pulsed low at count 5 -> no pulse, and key_db reads 4'hF during reset.
